// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scroll controller.
// Latency: none (package only).
// Backpressure: n/a.
package sseg_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SCROLL = 1'b1
    } state_t;

    localparam int         MAX_DIGITS = 8;
    localparam logic [3:0] DP_OFF     = 4'b1111;

    typedef logic [3:0] hex_digit_t;

    // (pos + k) mod len for pos < len <= 8 and k <= 3. The sum is below
    // len + 3, so three conditional subtractions give the exact result even
    // for len = 1, where the window repeats the single digit four times.
    function automatic logic [2:0] win_idx(input logic [2:0] pos,
                                           input logic [1:0] k,
                                           input logic [3:0] len);
        logic [3:0] s;
        s = {1'b0, pos} + {2'b00, k};
        for (int i = 0; i < 3; i++) begin
            if (s >= len) begin
                s = s - len;
            end
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/sseg_tick_gen.sv
// Scroll-rate tick generator: free counter that fires every TICK_MAX+1 enabled clocks.
// Latency: tick is combinational from the count and en; count updates next edge.
// Backpressure: en=0 freezes the count; clr restarts it from 0 and overrides en.
//
// Ports: clk, rst (sync, active-high), clr (restart), en (count), tick (period strobe).
module sseg_tick_gen #(
    parameter int TICK_MAX = 49_999_999,
    parameter int CNT_W    = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scroll_ctrl.sv
// Scrolls a 4-digit window circularly over a captured message of 1..8 hex digits.
// Latency: first window visible the cycle after acceptance; advance every TICK_MAX+1 unpaused clocks.
// Backpressure: msg_ready only in IDLE; pause freezes scrolling, stop aborts to IDLE.
//
// Ports: clk, rst (sync, active-high); msg_valid/msg_ready/msg_data/msg_dp/msg_len
// message handshake; pause, stop controls; hex3..hex0 digits (hex3 leftmost);
// dp_out active-low decimal points; busy, wrap, done status.
module sseg_scroll_ctrl
    import sseg_pkg::*;
#(
    parameter int TICK_MAX = 49_999_999,
    parameter int CNT_W    = 26,
    parameter int PASSES   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_data,
    input  logic [7:0]  msg_dp,
    input  logic [3:0]  msg_len,
    input  logic        pause,
    input  logic        stop,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic [3:0]  dp_out,
    output logic        busy,
    output logic        wrap,
    output logic        done
);

    state_t                         state_q, state_d;
    hex_digit_t [MAX_DIGITS-1:0]    digits_q;
    logic [MAX_DIGITS-1:0]          dp_q;
    logic [3:0]                     len_q;
    logic [2:0]                     pos_q;
    logic [7:0]                     pass_cnt_q;
    logic [7:0]                     pass_inc;
    logic                           accept;
    logic                           at_last;
    logic                           tick;
    logic                           tick_en;
    logic                           tick_clr;
    logic [2:0]                     idx0, idx1, idx2, idx3;

    // The counter is held clear in IDLE so the first scroll cycle starts at 0;
    // stop also clears it so an abort never leaves a stale phase behind.
    assign tick_en  = (state_q == SCROLL) && !pause;
    assign tick_clr = (state_q == IDLE) || stop;

    sseg_tick_gen #(
        .TICK_MAX (TICK_MAX),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    assign at_last  = ({1'b0, pos_q} == (len_q - 4'd1));
    // Saturates so an endless scroll never rolls the pass count back to 0.
    assign pass_inc = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;

    assign msg_ready = (state_q == IDLE);
    assign busy      = (state_q == SCROLL);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wrap    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-length message still completes the handshake but is dropped.
                if (msg_valid && (msg_len != 4'd0)) begin
                    accept  = 1'b1;
                    state_d = SCROLL;
                end
            end
            SCROLL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick && at_last) begin
                    wrap = 1'b1;
                    if ((PASSES != 0) && (pass_inc == 8'(PASSES))) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= '0;
            dp_q       <= '0;
            len_q      <= '0;
            pos_q      <= '0;
            pass_cnt_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits_q[i] <= msg_data[4*i +: 4];
            end
            dp_q       <= msg_dp;
            len_q      <= (msg_len > 4'(MAX_DIGITS)) ? 4'(MAX_DIGITS) : msg_len;
            pos_q      <= '0;
            pass_cnt_q <= '0;
        end else if ((state_q == SCROLL) && !stop && tick) begin
            pos_q <= at_last ? 3'd0 : pos_q + 3'd1;
            if (at_last) begin
                pass_cnt_q <= pass_inc;
            end
        end
    end

    // idxK is the message index shown K places right of the leftmost digit.
    assign idx0 = win_idx(pos_q, 2'd0, len_q);
    assign idx1 = win_idx(pos_q, 2'd1, len_q);
    assign idx2 = win_idx(pos_q, 2'd2, len_q);
    assign idx3 = win_idx(pos_q, 2'd3, len_q);

    always_comb begin
        hex3   = 4'h0;
        hex2   = 4'h0;
        hex1   = 4'h0;
        hex0   = 4'h0;
        dp_out = DP_OFF;
        if (state_q == SCROLL) begin
            hex3   = digits_q[idx0];
            hex2   = digits_q[idx1];
            hex1   = digits_q[idx2];
            hex0   = digits_q[idx3];
            dp_out = ~{dp_q[idx0], dp_q[idx1], dp_q[idx2], dp_q[idx3]};
        end
    end

endmodule
